chunked_addsub: RTL and testbench

- Multi-cycle, parametrised add/subtract unit and successor to the team's fixed 16-bit ripple subtractor.
- Processes operands W bits per clock through one W-bit borrow/carry slice.
- Operands are latched on a start handshake. Raises a one-cycle done pulse with result and status flags (borrow/carry, zero, signed overflow).
- Used by the datapath where a full-width combinational ripple chain is too long for timing.

---
 rtl/chunked_addsub_if.sv | 40 ++++
 rtl/chunked_addsub.sv | 136 +++++++++++++
 tb/tb_chunked_addsub.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/chunked_addsub_if.sv
// ----------------------------------------------------------------------------
// chunked_addsub_if
// Request/response bundle for the chunked add/subtract unit.
//   start_i  : request a new operation (sampled only while not busy)
//   mode_i   : 0 = subtract (a - b - cin), 1 = add (a + b + cin)
//   a_i, b_i : N-bit operands
//   cin_i    : borrow-in (subtract) or carry-in (add)
//   busy_o   : operation in progress
//   done_o   : one-cycle pulse, result and flags valid
//   result_o : N-bit difference/sum, held until the next completion
//   co_o     : borrow-out (subtract) or carry-out (add) of the MSB
//   zero_o   : result is zero
//   ovf_o    : two's-complement signed overflow
// Signal suffixes are from the point of view of the unit (slave).
// ----------------------------------------------------------------------------
interface chunked_addsub_if #(
    parameter int N = 16
);
    logic         start_i;
    logic         mode_i;
    logic [N-1:0] a_i;
    logic [N-1:0] b_i;
    logic         cin_i;
    logic         busy_o;
    logic         done_o;
    logic [N-1:0] result_o;
    logic         co_o;
    logic         zero_o;
    logic         ovf_o;

    modport master (
        output start_i, mode_i, a_i, b_i, cin_i,
        input  busy_o, done_o, result_o, co_o, zero_o, ovf_o
    );

    modport slave (
        input  start_i, mode_i, a_i, b_i, cin_i,
        output busy_o, done_o, result_o, co_o, zero_o, ovf_o
    );
endinterface

// File: rtl/chunked_addsub.sv
// ----------------------------------------------------------------------------
// chunked_addsub
// Multi-cycle add/subtract unit. Operands are latched on start and processed
// W bits per clock through a single W-bit borrow/carry slice, so the longest
// combinational chain is W bits instead of N. After K = N/W compute cycles
// the full result and its flags are published with a one-cycle done pulse.
// Ports:
//   clk_i : system clock, rising edge
//   rst_i : synchronous, active-high reset
//   bus   : chunked_addsub_if.slave request/response bundle
// ----------------------------------------------------------------------------
module chunked_addsub #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    chunked_addsub_if.slave     bus
);
    localparam int K  = N / W;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [N-1:0]  a_q, b_q;
    logic          mode_q;
    logic          chain_q;     // borrow/carry entering the current chunk
    logic [N-1:0]  part_q;      // chunks computed so far
    logic [N-1:0]  result_q;
    logic          co_q, zero_q, ovf_q;
    logic          busy_q, done_q;

    logic [W-1:0]  a_chunk, b_chunk, slice_d;
    logic          chain_d;
    logic [N-1:0]  part_d;
    logic          ovf_d;

    assign a_chunk = a_q[idx_q*W +: W];
    assign b_chunk = b_q[idx_q*W +: W];

    // One W-bit ripple slice; the chain is walked LSB to MSB inside the chunk.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        chain_d = chain_q;
        slice_d = '0;
        for (int j = 0; j < W; j++) begin
            slice_d[j] = a_chunk[j] ^ b_chunk[j] ^ chain_d;
            // NOTE: blocking assignments here are deliberate: chain_d must
            // carry bit j's result into bit j+1 within the same evaluation.
            if (mode_q) begin
                chain_d = (a_chunk[j] & b_chunk[j]) | ((a_chunk[j] ^ b_chunk[j]) & chain_d);
            end else begin
                chain_d = (~a_chunk[j] & b_chunk[j]) | (~(a_chunk[j] ^ b_chunk[j]) & chain_d);
            end
        end
    end

    // Full value including the chunk being produced this cycle.
    always_comb begin
        part_d = part_q;
        part_d[idx_q*W +: W] = slice_d;
    end

    // Signed overflow judged from operand signs against the result sign.
    assign ovf_d = mode_q ? ((a_q[N-1] == b_q[N-1]) && (part_d[N-1] != a_q[N-1]))
                          : ((a_q[N-1] != b_q[N-1]) && (part_d[N-1] != a_q[N-1]));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            chain_q  <= 1'b0;
            part_q   <= '0;
            result_q <= '0;
            co_q     <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start_i) begin
                        a_q     <= bus.a_i;
                        b_q     <= bus.b_i;
                        mode_q  <= bus.mode_i;
                        chain_q <= bus.cin_i;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    part_q  <= part_d;
                    chain_q <= chain_d;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        result_q <= part_d;
                        co_q     <= chain_d;
                        zero_q   <= (part_d == '0);
                        ovf_q    <= ovf_d;
                        idx_q    <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
    assign bus.co_o     = co_q;
    assign bus.zero_o   = zero_q;
    assign bus.ovf_o    = ovf_q;
endmodule

// File: tb/tb_chunked_addsub.sv
// ----------------------------------------------------------------------------
// tb_chunked_addsub
// Drives three instances (W = 4, 1, 16; N = 16) with identical stimulus and
// compares them against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_chunked_addsub;
    localparam int N = 16;

    typedef struct packed {
        logic [N-1:0] res;
        logic         co;
        logic         zero;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, mode, cin;
    logic [N-1:0] a, b;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-instance views: index 0 -> W=4, 1 -> W=1, 2 -> W=16.
    int           w_v [3] = '{4, 1, 16};
    int           k_v [3] = '{4, 16, 1};
    logic         busy_v [3];
    logic         done_v [3];
    logic [N-1:0] result_v [3];
    logic         co_v [3], zero_v [3], ovf_v [3];
    logic [N-1:0] prev_res [3];

    always #5 clk = ~clk;

    chunked_addsub_if #(.N(N)) if_w4  ();
    chunked_addsub_if #(.N(N)) if_w1  ();
    chunked_addsub_if #(.N(N)) if_w16 ();

    chunked_addsub #(.N(N), .W(4))  u_w4  (.clk_i(clk), .rst_i(rst), .bus(if_w4));
    chunked_addsub #(.N(N), .W(1))  u_w1  (.clk_i(clk), .rst_i(rst), .bus(if_w1));
    chunked_addsub #(.N(N), .W(16)) u_w16 (.clk_i(clk), .rst_i(rst), .bus(if_w16));

    assign if_w4.start_i  = start;  assign if_w1.start_i  = start;  assign if_w16.start_i  = start;
    assign if_w4.mode_i   = mode;   assign if_w1.mode_i   = mode;   assign if_w16.mode_i   = mode;
    assign if_w4.a_i      = a;      assign if_w1.a_i      = a;      assign if_w16.a_i      = a;
    assign if_w4.b_i      = b;      assign if_w1.b_i      = b;      assign if_w16.b_i      = b;
    assign if_w4.cin_i    = cin;    assign if_w1.cin_i    = cin;    assign if_w16.cin_i    = cin;

    assign busy_v[0] = if_w4.busy_o;     assign busy_v[1] = if_w1.busy_o;     assign busy_v[2] = if_w16.busy_o;
    assign done_v[0] = if_w4.done_o;     assign done_v[1] = if_w1.done_o;     assign done_v[2] = if_w16.done_o;
    assign result_v[0] = if_w4.result_o; assign result_v[1] = if_w1.result_o; assign result_v[2] = if_w16.result_o;
    assign co_v[0] = if_w4.co_o;         assign co_v[1] = if_w1.co_o;         assign co_v[2] = if_w16.co_o;
    assign zero_v[0] = if_w4.zero_o;     assign zero_v[1] = if_w1.zero_o;     assign zero_v[2] = if_w16.zero_o;
    assign ovf_v[0] = if_w4.ovf_o;       assign ovf_v[1] = if_w1.ovf_o;       assign ovf_v[2] = if_w16.ovf_o;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: integer arithmetic on the whole operands.
    function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                   input logic md, input logic ci);
        exp_t e;
        int   ua, ub, ic, r;
        ua = int'(av);
        ub = int'(bv);
        ic = ci ? 1 : 0;
        if (md) begin
            r    = ua + ub + ic;
            e.co = (r > 65535);
        end else begin
            r    = ua - ub - ic;
            e.co = (ua < ub + ic);
        end
        e.res  = N'(r);
        e.zero = (e.res == '0);
        if (md) e.ovf = (av[N-1] == bv[N-1]) && (e.res[N-1] != av[N-1]);
        else    e.ovf = (av[N-1] != bv[N-1]) && (e.res[N-1] != av[N-1]);
        return e;
    endfunction

    task automatic check_result(input int d, input string tag, input exp_t e);
        check($sformatf("%s_w%0d_res", tag, w_v[d]),  32'(result_v[d]), 32'(e.res));
        check($sformatf("%s_w%0d_co", tag, w_v[d]),   32'(co_v[d]),     32'(e.co));
        check($sformatf("%s_w%0d_zero", tag, w_v[d]), 32'(zero_v[d]),   32'(e.zero));
        check($sformatf("%s_w%0d_ovf", tag, w_v[d]),  32'(ovf_v[d]),    32'(e.ovf));
    endtask

    // One operation on all instances; operands are scrambled right after
    // acceptance, and latency, flags and result hold-during-RUN are checked.
    task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                          input logic md, input logic ci, input string tag);
        exp_t e;
        int   seen [3];
        int   ndone [3];
        e = model(av, bv, md, ci);
        for (int d = 0; d < 3; d++) begin
            seen[d]  = -1;
            ndone[d] = 0;
        end
        a = av; b = bv; mode = md; cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = N'($urandom); b = N'($urandom); mode = 1'($urandom); cin = 1'($urandom);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_w%0d_busy", tag, w_v[d]), 32'(busy_v[d]), 32'd1);
            check($sformatf("%s_w%0d_hold", tag, w_v[d]), 32'(result_v[d]), 32'(prev_res[d]));
        end
        for (int c = 0; c < 24; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            for (int d = 0; d < 3; d++) begin
                if (done_v[d]) begin
                    ndone[d]++;
                    if (seen[d] < 0) begin
                        seen[d] = c;
                        check_result(d, tag, e);
                        check($sformatf("%s_w%0d_busy_at_done", tag, w_v[d]), 32'(busy_v[d]), 32'd0);
                        prev_res[d] = e.res;
                    end
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_w%0d_latency", tag, w_v[d]), 32'(seen[d]), 32'(k_v[d]));
            check($sformatf("%s_w%0d_ndone", tag, w_v[d]), 32'(ndone[d]), 32'd1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_w%0d_busy", tag, w_v[d]), 32'(busy_v[d]), 32'd0);
            check($sformatf("%s_w%0d_done", tag, w_v[d]), 32'(done_v[d]), 32'd0);
            check_result(d, tag, exp_t'(0));
            prev_res[d] = '0;
        end
    endtask

    logic [N-1:0] ha [40];
    logic [N-1:0] hb [40];
    logic         hm [40];
    logic         hc [40];

    initial begin
        int   nd;
        exp_t e;
        logic exp_done;

        // Reset held two cycles with start asserted.
        rst = 1'b1; start = 1'b1;
        a = N'($urandom); b = N'($urandom); mode = 1'($urandom); cin = 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_all_zero($sformatf("reset%0d", i));
        end
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check_all_zero("post_reset");

        // Directed cases.
        run_op(16'h1234, 16'h0234, 1'b0, 1'b0, "sub_basic");
        run_op(16'h0000, 16'h0001, 1'b0, 1'b0, "sub_wrap");
        run_op(16'h8000, 16'h0001, 1'b0, 1'b0, "sub_ovf");
        run_op(16'h0005, 16'h0004, 1'b0, 1'b1, "sub_zero_cin");
        run_op(16'hFFFF, 16'h0001, 1'b1, 1'b0, "add_wrap");
        run_op(16'h7FFF, 16'h0001, 1'b1, 1'b0, "add_ovf");
        run_op(16'h7FFF, 16'h0000, 1'b1, 1'b1, "add_cin_ovf");

        // Random operations.
        for (int i = 0; i < 12; i++) begin
            run_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom),
                   $sformatf("rand%0d", i));
        end

        // Reset on the second RUN cycle.
        a = 16'h4321; b = 16'h1111; mode = 1'b1; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("abort");
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) if (done_v[d] || busy_v[d]) nd++;
        end
        check("abort_no_activity", 32'(nd), 32'd0);
        run_op(16'h1234, 16'h0234, 1'b0, 1'b0, "after_abort");

        // start held high with operands changing every cycle.
        for (int c = 0; c < 40; c++) begin
            ha[c] = N'($urandom); hb[c] = N'($urandom);
            hm[c] = 1'($urandom); hc[c] = 1'($urandom);
            a = ha[c]; b = hb[c]; mode = hm[c]; cin = hc[c]; start = 1'b1;
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                exp_done = (c % (k_v[d] + 1)) == k_v[d];
                check($sformatf("hs_c%0d_w%0d_done", c, w_v[d]), 32'(done_v[d]), 32'(exp_done));
                if (exp_done) begin
                    e = model(ha[c-k_v[d]], hb[c-k_v[d]], hm[c-k_v[d]], hc[c-k_v[d]]);
                    check_result(d, $sformatf("hs_c%0d", c), e);
                end
            end
        end
        start = 1'b0;
        repeat (20) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
